// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: two round-robin requesters share one
// W-bit ripple-carry slice that is stepped once per word, least-significant first.

module ripple_carry_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[N];
  end
endmodule

// state | meaning
// IDLE  | arbitrate requesters, accept one operation
// RUN   | one word through the slice per cycle, carry chained in carry_q
// DONE  | result held on rsp_* until the consumer takes it
module mp_add_sequencer #(
  parameter int W     = 32,
  parameter int WORDS = 4,
  parameter int OW    = W * WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [OW-1:0] req0_a,
  input  logic [OW-1:0] req0_b,
  input  logic          req0_ci,
  input  logic          req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [OW-1:0] req1_a,
  input  logic [OW-1:0] req1_b,
  input  logic          req1_ci,
  input  logic          req1_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [OW-1:0] rsp_sum,
  output logic          rsp_co,
  output logic          rsp_ovf,
  output logic          busy
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [OW-1:0] a_q, a_d;
  logic [OW-1:0] b_q, b_d;
  logic          op_q, op_d;
  logic          id_q, id_d;
  logic          last_grant_q, last_grant_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [OW-1:0] sum_q, sum_d;
  logic          co_q, co_d;
  logic          ovf_q, ovf_d;

  logic          any_valid;
  logic          grant;
  logic [31:0]   base;
  logic [W-1:0]  slice_a, slice_b, slice_s;
  logic          slice_co;

  // A tie goes to the requester that did not win last time.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  assign req0_ready = !rst && (state_q == IDLE) && any_valid && (grant == 1'b0);
  assign req1_ready = !rst && (state_q == IDLE) && any_valid && (grant == 1'b1);

  always_comb begin
    base    = 32'(idx_q) * 32'(W);
    slice_a = a_q[base +: W];
    slice_b = b_q[base +: W] ^ {W{op_q}};
  end

  ripple_carry_adder #(.N(W)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    sum_d        = sum_q;
    co_d         = co_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          a_d          = grant ? req1_a  : req0_a;
          b_d          = grant ? req1_b  : req0_b;
          op_d         = grant ? req1_op : req0_op;
          carry_d      = op_d ? 1'b1 : (grant ? req1_ci : req0_ci);
          id_d         = grant;
          last_grant_d = grant;
          idx_d        = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        sum_d[base +: W] = slice_s;
        carry_d          = slice_co;
        idx_d            = idx_q + 1'b1;
        if (idx_q == IW'(WORDS - 1)) begin
          idx_d       = '0;
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          co_d        = slice_co;
          ovf_d       = (slice_a[W-1] == slice_b[W-1]) && (slice_s[W-1] != slice_a[W-1]);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      sum_q        <= '0;
      co_q         <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      sum_q        <= sum_d;
      co_q         <= co_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = sum_q;
  assign rsp_co    = co_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = (state_q == RUN) || (state_q == DONE);
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer (W=32, WORDS=4) with hand-computed results.

module tb_mp_add_sequencer;
  localparam int W = 32;
  localparam int WORDS = 4;
  localparam int OW = W * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_ci, req0_op;
  logic [OW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_ci, req1_op;
  logic [OW-1:0] req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_co, rsp_ovf, busy;
  logic [OW-1:0] rsp_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mp_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ci(req0_ci), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ci(req1_ci), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_co(rsp_co), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic [OW-1:0] a, input logic [OW-1:0] b,
                         input logic ci, input logic op);
    if (n == 0) begin
      req0_a = a; req0_b = b; req0_ci = ci; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_ci = ci; req1_op = op; req1_valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issues one op on requester n, leaves it unacknowledged in DONE, returns latency.
  task automatic issue(input int n, input logic [OW-1:0] a, input logic [OW-1:0] b,
                       input logic ci, input logic op, output int lat);
    int k;
    logic rdy;
    set_req(n, a, b, ci, op);
    k = 0;
    rdy = 1'b0;
    while (!rdy && k < 20) begin
      @(negedge clk);
      rdy = (n == 0) ? req0_ready : req1_ready;
      k++;
    end
    if (!rdy) chk("accept_timeout", 128'(rdy), 128'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_op(input string tag, input int n, input logic [OW-1:0] a,
                          input logic [OW-1:0] b, input logic ci, input logic op,
                          input logic [OW-1:0] esum, input logic eco, input logic eovf);
    int lat;
    issue(n, a, b, ci, op, lat);
    chk({tag, "_lat"}, 128'(lat), 128'(WORDS));
    chk({tag, "_sum"}, rsp_sum, esum);
    chk({tag, "_co"},  128'(rsp_co), 128'(eco));
    chk({tag, "_ovf"}, 128'(rsp_ovf), 128'(eovf));
    chk({tag, "_id"},  128'(rsp_id), 128'(n));
    ack();
  endtask

  initial begin
    int lat;
    int got;
    int ids[4];
    logic [OW-1:0] snap_sum;
    logic snap_co, snap_ovf, snap_id;

    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ci = 1'b0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0; req1_op = 1'b0;
    do_reset();

    @(negedge clk);
    chk("rst_valid", 128'(rsp_valid), 128'd0);
    chk("rst_sum", rsp_sum, '0);
    chk("rst_misc", 128'({rsp_id, rsp_co, rsp_ovf, busy}), 128'd0);
    chk("rst_readys", 128'({req0_ready, req1_ready}), 128'd0);
    req0_valid = 1'b1;
    #1;
    chk("idle_readys", 128'({req0_ready, req1_ready}), 128'b10);
    req0_valid = 1'b0;
    @(posedge clk); #1;

    check_op("carry", 0, {32'h0, {96{1'b1}}}, 128'd1, 1'b0, 1'b0,
             {32'h1, 96'h0}, 1'b0, 1'b0);
    check_op("wrap", 0, {128{1'b1}}, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1, 1'b0);
    check_op("sub0", 0, 128'd0, 128'd1, 1'b0, 1'b1, {128{1'b1}}, 1'b0, 1'b0);
    check_op("subov", 1, {32'h8000_0000, 96'h0}, 128'd1, 1'b1, 1'b1,
             {32'h7FFF_FFFF, {96{1'b1}}}, 1'b1, 1'b1);

    // round-robin from a fresh reset: req0 first
    do_reset();
    set_req(0, 128'd1, 128'd2, 1'b0, 1'b0);
    set_req(1, 128'd3, 128'd4, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids[got] = int'(rsp_id);
        got++;
      end
    end
    rsp_ready = 1'b0;
    chk("rr_count", 128'(got), 128'd4);
    chk("rr_seq", 128'({ids[0][0], ids[1][0], ids[2][0], ids[3][0]}), 128'b0101);
    @(posedge clk); #1;
    while (rsp_valid) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    while (busy) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;

    // backpressure: hold DONE for 10 cycles with both requesters asking
    issue(0, 128'h1234, 128'h1111, 1'b0, 1'b0, lat);
    chk("bp_lat", 128'(lat), 128'(WORDS));
    snap_sum = rsp_sum; snap_co = rsp_co; snap_ovf = rsp_ovf; snap_id = rsp_id;
    chk("bp_sum", snap_sum, 128'h2345);
    set_req(0, 128'd9, 128'd9, 1'b0, 1'b0);
    set_req(1, 128'd9, 128'd9, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_sum[OW-5:0], rsp_valid, rsp_co, rsp_ovf, rsp_id},
          {snap_sum[OW-5:0], 1'b1, snap_co, snap_ovf, snap_id});
      chk("bp_ready_busy", 128'({req0_ready, req1_ready, busy}), 128'b001);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ack();

    // reset in the middle of RUN at idx=2
    set_req(0, 128'd100, 128'd200, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst", 128'({rsp_valid, busy}), 128'd0);
    for (int c = 0; c < 6; c++) @(posedge clk);
    #1;
    chk("mid_rst_quiet", 128'({rsp_valid, busy}), 128'd0);
    check_op("after_rst", 1, 128'd5, 128'd7, 1'b0, 1'b0, 128'd12, 1'b0, 1'b0);

    set_req(0, 128'd1, 128'd1, 1'b0, 1'b0);
    set_req(1, 128'd2, 128'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("tie_after_rst", 128'({req0_ready, req1_ready}), 128'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
- Multi-precision add/subtract engine built around one W-bit ripple-carry adder slice (ripple_carry_adder, N=W).
- Accepts wide operands (W*WORDS bits) from two requesters and arbitrates between them round-robin.
- Sequences the slice once per word, least-significant word first, chaining carry through a register.
- Returns the wide result through a valid/ready response port; sits between client logic and the shared adder datapath.

Parameters:
- W, 32, adder slice width in bits.
- WORDS, 4, number of W-bit words per operand; operand width OW = W*WORDS; WORDS >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- reqN_valid  in  1  (N=0,1) requester N has an operation pending.
- reqN_ready  out  1  requester N's operation is accepted on this edge when valid is also high.
- reqN_a  in  OW  operand A.
- reqN_b  in  OW  operand B.
- reqN_ci  in  1  carry-in; used for add only.
- reqN_op  in  1  0 = A+B+ci; 1 = A-B, computed as A + ~B + 1 with ci ignored.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  index of the requester that issued the result.
- rsp_sum  out  OW  result.
- rsp_co  out  1  final carry-out; for subtract, 1 = no borrow.
- rsp_ovf  out  1  two's-complement signed overflow of the OW-bit result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset:
  - state = IDLE; rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf, busy all 0.
  - Word index and carry register = 0; last_grant = 1, so req0 wins the first tie.
  - Reset mid-operation abandons the operation; nothing is emitted.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - grant = the valid requester. If both are valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) && (grant==N); it is combinational from valid and state. Both readys are low in RUN, DONE and reset.
  - On an accepting edge: capture a, b, op and id; set idx=0; carry = op ? 1 : ci; last_grant = id; go to RUN.
  - Valid dropped without a handshake has no effect.
- RUN, one word per cycle:
  - sum[idx] = a[idx] + (b[idx] ^ {W{op}}) + carry; the carry register takes the slice carry-out; idx increments.
  - On the edge that writes word WORDS-1: go to DONE and set rsp_valid=1.
  - rsp_co = slice carry-out of the top word.
  - rsp_ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the (possibly inverted) B.
- Latency: rsp_valid rises exactly WORDS cycles after the accepting edge.
- DONE:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On the edge with rsp_valid && rsp_ready: rsp_valid=0, go to IDLE.
  - rsp_sum, rsp_co, rsp_ovf and rsp_id keep their last values until they are overwritten.
  - No new acceptance in the handshake cycle. Peak throughput is one operation per WORDS+2 cycles.
- rsp_sum words not yet written during RUN may show stale data; they are only meaningful while rsp_valid is high.
- Arithmetic is modulo 2^OW; there is no saturation.

Test Plan:
- Reset then idle: after rst, all outputs 0 and both readys 0 with no valid. Raise req0_valid -> req0_ready=1 that cycle, req1_ready=0.
- Carry chain (W=32, WORDS=4):
  - Stimulus: req0 add, a=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1, ci=0.
  - Required: rsp_sum=0x00000001_00000000_00000000_00000000, co=0, ovf=0, rsp_id=0.
  - rsp_valid rises exactly 4 cycles after the accept edge.
- Wrap and carry-in: a=all ones, b=0, ci=1 -> rsp_sum=0, rsp_co=1, rsp_ovf=0.
- Subtract:
  - a=0, b=1, op=1 -> sum=all ones, co=0, ovf=0.
  - a=0x80000000_00000000_00000000_00000000, b=1, op=1 -> sum=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, co=1, ovf=1.
- Arbitration and backpressure:
  - Both requesters held valid for 4 operations -> rsp_id sequence 0,1,0,1.
  - rsp_ready held low 10 cycles in DONE -> rsp_* stable, both readys 0, busy=1.
- Reset mid-operation:
  - Assert rst for 1 cycle while idx=2 -> next cycle IDLE, rsp_valid=0, busy=0.
  - A following req1 add of 5+7 -> rsp_sum=12 with rsp_id=1, and req0 wins any tie afterwards.
